// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter.
package regfile_pkg;

  // Register-file address width (32 architectural registers).
  localparam int REG_ADDR_W = 5;

  // Default register data width.
  localparam int XLEN_DEFAULT = 32;

  // Requester indices into the request and grant vectors.
  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;

  // One bit per requester, indexed by REQ_ALU / REQ_LSU.
  typedef logic [1:0] req_vec_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The grant is combinational. The
// priority pointer moves only on contended cycles, and it moves to the
// requester that lost.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  req_vec_t req_i,
  output req_vec_t gnt_o,
  output logic     rr_ptr_o
);

  logic rr_ptr_q;
  logic rr_ptr_d;
  logic contended;

  assign contended = req_i[REQ_ALU] & req_i[REQ_LSU];

  // Grant: a lone requester always wins; under contention the pointer decides.
  always_comb begin
    gnt_o          = '0;
    gnt_o[REQ_ALU] = req_i[REQ_ALU] & (~req_i[REQ_LSU] | (rr_ptr_q == 1'(REQ_ALU)));
    gnt_o[REQ_LSU] = req_i[REQ_LSU] & (~req_i[REQ_ALU] | (rr_ptr_q == 1'(REQ_LSU)));
  end

  // Next pointer: after a contended cycle, hand priority to the loser.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (contended) begin
      rr_ptr_d = gnt_o[REQ_ALU] ? 1'(REQ_LSU) : 1'(REQ_ALU);
    end
  end

  // Pointer register; reset gives the ALU priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= 1'(REQ_ALU);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign rr_ptr_o = rr_ptr_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter between the ALU and the LSU in front of the register file.
// Optional feature macro: WB_FORWARD_EN. When it is defined, the writeback
// value in flight is forwarded onto the rs1/rs2 operand outputs.
//
// Handshake: each requester raises valid and holds addr and data stable
// until ready. Ready is combinational from the valids. A transfer happens
// at a rising edge where valid and ready are both high. The write appears
// on wr_* for the cycle after the transfer.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_addr_i,
  input  logic [XLEN-1:0]       alu_data_i,
  output logic                  alu_ready_o,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_addr_i,
  input  logic [XLEN-1:0]       lsu_data_i,
  output logic                  lsu_ready_o,
  output logic                  wr_enable_o,
  output logic [REG_ADDR_W-1:0] wr_addr_o,
  output logic [XLEN-1:0]       wr_data_o,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [XLEN-1:0]       rs1_rf_i,
  input  logic [XLEN-1:0]       rs2_rf_i,
  output logic [XLEN-1:0]       rs1_o,
  output logic [XLEN-1:0]       rs2_o,
  output logic [CNT_W-1:0]      contention_cnt_o,
  output logic                  rr_ptr_o
);

  req_vec_t req;
  req_vec_t gnt;

  logic                  wr_en_q,   wr_en_d;
  logic [REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;

  assign req[REQ_ALU] = alu_valid_i;
  assign req[REQ_LSU] = lsu_valid_i;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_i    (req),
    .gnt_o    (gnt),
    .rr_ptr_o (rr_ptr_o)
  );

  // Nothing is granted while reset is held, so a request cannot slip through.
  assign alu_ready_o = gnt[REQ_ALU] & reset_n;
  assign lsu_ready_o = gnt[REQ_LSU] & reset_n;

  // Capture the granted write. Address 0 is accepted but never strobed.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_ready_o) begin
      wr_en_d   = |alu_addr_i;
      wr_addr_d = alu_addr_i;
      wr_data_d = alu_data_i;
    end else if (lsu_ready_o) begin
      wr_en_d   = |lsu_addr_i;
      wr_addr_d = lsu_addr_i;
      wr_data_d = lsu_data_i;
    end
  end

  // Count contended cycles, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (alu_valid_i && lsu_valid_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Writeback and counter registers; reset drops any pending write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_enable_o      = wr_en_q;
  assign wr_addr_o        = wr_addr_q;
  assign wr_data_o        = wr_data_q;
  assign contention_cnt_o = cnt_q;

`ifdef WB_FORWARD_EN
  // Bypass: a read of the register being written this cycle sees the new value.
  always_comb begin
    rs1_o = rs1_rf_i;
    rs2_o = rs2_rf_i;
    if (wr_en_q && (wr_addr_q == rs1_addr_i) && (rs1_addr_i != '0)) begin
      rs1_o = wr_data_q;
    end
    if (wr_en_q && (wr_addr_q == rs2_addr_i) && (rs2_addr_i != '0)) begin
      rs2_o = wr_data_q;
    end
  end
`else
  // No bypass. The read addresses go straight to the register file and
  // are not used here.
  logic unused_rs_addr;
  assign unused_rs_addr = ^{rs1_addr_i, rs2_addr_i};

  // Operands come straight from the register file.
  always_comb begin
    rs1_o = rs1_rf_i;
    rs2_o = rs2_rf_i;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter. It runs directed scenarios, then
// randomized traffic. The expected results come from a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam int EW    = 1 + 1 + 5 + XLEN + CNT_W;  // en, ptr, addr, data, cnt
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic            alu_valid_i, lsu_valid_i, alu_ready_o, lsu_ready_o;
  logic [4:0]      alu_addr_i, lsu_addr_i, wr_addr_o, rs1_addr_i, rs2_addr_i;
  logic [XLEN-1:0] alu_data_i, lsu_data_i, wr_data_o, rs1_rf_i, rs2_rf_i, rs1_o, rs2_o;
  logic            wr_enable_o, rr_ptr_o;
  logic [CNT_W-1:0] contention_cnt_o;

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid_i(alu_valid_i), .alu_addr_i(alu_addr_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i), .lsu_addr_i(lsu_addr_i), .lsu_data_i(lsu_data_i), .lsu_ready_o(lsu_ready_o),
    .wr_enable_o(wr_enable_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rs1_rf_i(rs1_rf_i), .rs2_rf_i(rs2_rf_i),
    .rs1_o(rs1_o), .rs2_o(rs2_o), .contention_cnt_o(contention_cnt_o), .rr_ptr_o(rr_ptr_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The model holds the priority holder, the saturating contention count and
  // the write that is visible on wr_* right now.
  logic [EW-1:0] exp_q[$];
  int            m_prio;          // requester that wins the next contention
  int            m_cnt;
  bit            m_en;
  logic [4:0]    m_addr;
  logic [XLEN-1:0] m_data;
  bit            m_galu, m_glsu;  // grants the model predicts for the coming edge
  int            m_winner;
  logic [XLEN-1:0] m_rs1, m_rs2;

  function automatic logic [XLEN-1:0] fwd_val(input logic [4:0] ra, input logic [XLEN-1:0] rf);
    if (FWD && m_en && (m_addr == ra) && (ra != 0)) return m_data;
    return rf;
  endfunction

  // The model samples the inputs at the falling edge, checks the ready and
  // operand outputs, and predicts the write for the next rising edge.
  always @(negedge clk) begin
    if (!reset_n) begin
      m_prio = 0; m_cnt = 0; m_en = 0; m_addr = '0; m_data = '0;
      m_galu = 0; m_glsu = 0;
      exp_q.delete();
      chk("ready_alu_in_reset", alu_ready_o, 0);
      chk("ready_lsu_in_reset", lsu_ready_o, 0);
    end else begin
      if (alu_valid_i && lsu_valid_i) m_winner = m_prio;
      else if (alu_valid_i)           m_winner = 0;
      else if (lsu_valid_i)           m_winner = 1;
      else                            m_winner = -1;
      m_galu = (m_winner == 0);
      m_glsu = (m_winner == 1);
      chk("alu_ready", alu_ready_o, m_galu);
      chk("lsu_ready", lsu_ready_o, m_glsu);
      m_rs1 = fwd_val(rs1_addr_i, rs1_rf_i);
      m_rs2 = fwd_val(rs2_addr_i, rs2_rf_i);
      chk("rs1_o", rs1_o, m_rs1);
      chk("rs2_o", rs2_o, m_rs2);
      if (alu_valid_i && lsu_valid_i) begin
        m_prio = 1 - m_winner;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (m_winner == 0) begin
        m_addr = alu_addr_i; m_data = alu_data_i; m_en = (alu_addr_i != 0);
      end else if (m_winner == 1) begin
        m_addr = lsu_addr_i; m_data = lsu_data_i; m_en = (lsu_addr_i != 0);
      end else begin
        m_en = 0;
      end
      exp_q.push_back({m_en, 1'(m_prio), m_addr, m_data, CNT_W'(m_cnt)});
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [EW-1:0] e;
  always @(posedge clk) begin
    #1;
    if (reset_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("wr_enable", wr_enable_o, e[EW-1]);
      chk("rr_ptr", rr_ptr_o, e[EW-2]);
      if (e[EW-1]) begin
        chk("wr_addr", wr_addr_o, e[EW-3 -: 5]);
        chk("wr_data", wr_data_o, e[CNT_W +: XLEN]);
      end
      chk("contention_cnt", contention_cnt_o, e[CNT_W-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input bit av, input logic [4:0] aa, input logic [XLEN-1:0] ad,
                       input bit lv, input logic [4:0] la, input logic [XLEN-1:0] ld);
    alu_valid_i = av; alu_addr_i = aa; alu_data_i = ad;
    lsu_valid_i = lv; lsu_addr_i = la; lsu_data_i = ld;
  endtask

  task automatic idle();
    drive(0, '0, '0, 0, '0, '0);
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset_n = 1'b0;
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    repeat (3) @(posedge clk);
    #2;
    idle();
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    drive(1, 5'd1, 32'h11, 1, 5'd2, 32'h22);
    rs1_addr_i = '0; rs2_addr_i = '0; rs1_rf_i = '0; rs2_rf_i = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wr_enable", wr_enable_o, 0);
    chk("rst_wr_addr", wr_addr_o, 0);
    chk("rst_wr_data", wr_data_o, 0);
    chk("rst_cnt", contention_cnt_o, 0);
    chk("rst_rr_ptr", rr_ptr_o, 0);
    chk("rst_alu_ready", alu_ready_o, 0);
    chk("rst_lsu_ready", lsu_ready_o, 0);
    idle();
    reset_n = 1'b1;

    // Single ALU write right after reset release.
    drive(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
    #1;
    chk("single_alu_ready", alu_ready_o, 1);
    chk("single_lsu_ready", lsu_ready_o, 0);
    step();
    idle();
    chk("single_wr_enable", wr_enable_o, 1);
    chk("single_wr_addr", wr_addr_o, 5);
    chk("single_wr_data", wr_data_o, 32'hDEADBEEF);
    step();
    chk("idle_wr_enable", wr_enable_o, 0);
    chk("idle_wr_addr_hold", wr_addr_o, 5);
    chk("idle_wr_data_hold", wr_data_o, 32'hDEADBEEF);

    // Contention right after reset: the ALU wins first, then the LSU.
    do_reset();
    drive(1, 5'd3, 32'hA0A0_0003, 1, 5'd4, 32'hB0B0_0004);
    #1;
    chk("cont1_alu_ready", alu_ready_o, 1);
    chk("cont1_lsu_ready", lsu_ready_o, 0);
    step();
    chk("cont1_wr_addr", wr_addr_o, 3);
    #1;
    chk("cont2_alu_ready", alu_ready_o, 0);
    chk("cont2_lsu_ready", lsu_ready_o, 1);
    step();
    idle();
    chk("cont2_wr_addr", wr_addr_o, 4);
    chk("cont2_wr_data", wr_data_o, 32'hB0B0_0004);
    chk("cont2_cnt", contention_cnt_o, 2);

    // A write to x0 is accepted but never strobed.
    drive(0, '0, '0, 1, 5'd0, 32'h12345678);
    #1;
    chk("x0_lsu_ready", lsu_ready_o, 1);
    step();
    idle();
    chk("x0_wr_enable", wr_enable_o, 0);

    // Forwarding of the write in flight onto rs1.
    drive(1, 5'd7, 32'hCAFEF00D, 0, '0, '0);
    step();
    idle();
    rs1_addr_i = 5'd7; rs1_rf_i = '0;
    #1;
    chk("fwd_wr_enable", wr_enable_o, 1);
    chk("fwd_rs1", rs1_o, FWD ? 32'hCAFEF00D : 32'h0);
    step();
    rs1_rf_i = 32'h55;
    #1;
    chk("nofwd_rs1", rs1_o, 32'h55);
    rs1_addr_i = '0; rs1_rf_i = '0;

    // Sustained contention: the grants alternate and the counter saturates.
    do_reset();
    drive(1, 5'd10, 32'h0A0A, 1, 5'd11, 32'h0B0B);
    for (int i = 0; i < 300; i++) begin
      #1;
      chk("alt_alu_ready", alu_ready_o, (i % 2) == 0);
      step();
    end
    chk("sat_cnt", contention_cnt_o, 255);

    // Reset arrives mid-cycle while a captured write is on wr_*.
    step();
    chk("pre_rst_wr_enable", wr_enable_o, 1);
    chk("pre_rst_rr_ptr", rr_ptr_o, 1);
    #1;
    reset_n = 1'b0;
    idle();
    #1;
    chk("mid_rst_wr_enable", wr_enable_o, 0);
    chk("mid_rst_rr_ptr", rr_ptr_o, 0);
    chk("mid_rst_cnt", contention_cnt_o, 0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Randomized traffic. A requester keeps its request until it is granted.
    for (int i = 0; i < 2000; i++) begin
      if (!alu_valid_i || m_galu) begin
        alu_valid_i = ($urandom_range(0, 99) < 60);
        alu_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        alu_data_i  = $urandom;
      end
      if (!lsu_valid_i || m_glsu) begin
        lsu_valid_i = ($urandom_range(0, 99) < 60);
        lsu_addr_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        lsu_data_i  = $urandom;
      end
      rs1_addr_i = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
      rs2_addr_i = $urandom_range(0, 1) ? m_addr : 5'($urandom_range(0, 31));
      rs1_rf_i   = $urandom;
      rs2_rf_i   = $urandom;
      step();
    end
    idle();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, data width of register write/read values.
REQ-002 Parameter CNT_W, default 8, width of the contention counter.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 alu_valid_i  input  1  ALU writeback request.
REQ-006 alu_addr_i  input  5  ALU destination register.
REQ-007 alu_data_i  input  XLEN  ALU result.
REQ-008 alu_ready_o  output  1  ALU request granted this cycle.
REQ-009 lsu_valid_i / lsu_addr_i / lsu_data_i / lsu_ready_o  same widths and meaning for the load/store unit.
REQ-010 wr_enable_o  output  1  write strobe to register file.
REQ-011 wr_addr_o  output  5  write address to register file.
REQ-012 wr_data_o  output  XLEN  write data to register file.
REQ-013 rs1_addr_i / rs2_addr_i  input  5  read addresses, also driven to the register file.
REQ-014 rs1_rf_i / rs2_rf_i  input  XLEN  raw register-file read data.
REQ-015 rs1_o / rs2_o  output  XLEN  operand values delivered to the datapath.
REQ-016 contention_cnt_o  output  CNT_W  number of cycles both requesters were valid.

Function
REQ-017 Transfer occurs when valid and ready are both high at a rising edge; a requester holds valid, addr and data stable until ready.
REQ-018 ready is combinational: alu_ready_o = alu_valid_i & (!lsu_valid_i | rr_ptr==0); lsu_ready_o = lsu_valid_i & (!alu_valid_i | rr_ptr==1).
REQ-019 At most one ready high per cycle; no grant without valid.
REQ-020 rr_ptr updates only on a contended cycle (both valid): it moves to the requester not granted; uncontended grants leave it unchanged.
REQ-021 Latency one cycle: transfer at edge N drives wr_enable_o=1 with captured addr/data for cycle N+1.
REQ-022 Cycles without transfer drive wr_enable_o=0; wr_addr_o/wr_data_o hold last value.
REQ-023 Transfer to address 0 is accepted (ready high) but wr_enable_o stays 0 the following cycle.
REQ-024 contention_cnt_o increments on every contended cycle and saturates at all-ones.
REQ-025 Back-to-back transfers from the same requester on consecutive cycles are permitted when uncontended.

Reset
REQ-026 reset_n low asynchronously forces wr_enable_o=0, wr_addr_o=0, wr_data_o=0, rr_ptr=0 (ALU priority), contention_cnt_o=0.
REQ-027 While reset_n is low, both ready outputs are 0; a write pending at reset assertion is dropped.
REQ-028 First grant may occur on the first rising edge after reset_n deasserts.

Configuration
REQ-029 Macro WB_FORWARD_EN defined: rsN_o = wr_data_o when wr_enable_o=1 and wr_addr_o==rsN_addr_i and rsN_addr_i!=0, else rsN_rf_i.
REQ-030 WB_FORWARD_EN undefined: rsN_o = rsN_rf_i unconditionally; no comparators synthesised.

Structure
REQ-031 Package regfile_pkg holds REG_ADDR_W=5, XLEN default, and requester index constants REQ_ALU=0, REQ_LSU=1.
REQ-032 Sub-module rr_arbiter2 implements REQ-018/REQ-020 (two requests, grant vector, rr_ptr); regfile_wb_arbiter instantiates it once.

Verification
REQ-033 ALU alone valid, addr 5, data 0xDEADBEEF -> alu_ready_o=1 same cycle; next cycle wr_enable_o=1, wr_addr_o=5, wr_data_o=0xDEADBEEF.
REQ-034 Both valid after reset (ALU addr 3, LSU addr 4), held 2 cycles -> ALU granted cycle 1, LSU cycle 2; contention_cnt_o=2.
REQ-035 LSU valid, addr 0, data 0x12345678 -> lsu_ready_o=1; following cycle wr_enable_o=0.
REQ-036 WB_FORWARD_EN defined, ALU writes 0xCAFEF00D to x7, rs1_addr_i=7, rs1_rf_i=0 during the write cycle -> rs1_o=0xCAFEF00D; undefined -> rs1_o=0.
REQ-037 Both valid continuously for 300 cycles with CNT_W=8 -> grants alternate every cycle, contention_cnt_o=255.
REQ-038 reset_n asserted mid-cycle with a transfer captured -> wr_enable_o=0 immediately, rr_ptr=0, contention_cnt_o=0.
